// File: rtl/mem_access_if.sv
// MEM-stage bundle: EX-side memory op in, data-RAM request/ready bus, WB result out.
// Latency: n/a (signal bundle only).
// Backpressure: stall_req travels back to EX; ram_ready completes a RAM access.
//
// Ports (slave = the MEM stage itself, master = its surroundings):
//   EX side : ex_valid, mem_*_in, result_in, reg_write_*_in, current_pc_addr_in,
//             stall_req, mem_load_flag
//   RAM side: ram_en, ram_write_en, ram_addr, ram_write_data, ram_ready, ram_read_data
//   WB side : wb_valid, result_out, reg_write_*_out, current_pc_addr_out,
//             misalign_flag, bus_error_flag
interface mem_access_if;
    logic        ex_valid;
    logic        mem_read_flag_in;
    logic        mem_write_flag_in;
    logic        mem_sign_ext_flag_in;
    logic [3:0]  mem_sel_in;
    logic [31:0] mem_write_data_in;
    logic [31:0] result_in;
    logic        reg_write_en_in;
    logic [4:0]  reg_write_addr_in;
    logic [31:0] current_pc_addr_in;
    logic        stall_req;
    logic        mem_load_flag;
    logic        ram_en;
    logic [3:0]  ram_write_en;
    logic [31:0] ram_addr;
    logic [31:0] ram_write_data;
    logic        ram_ready;
    logic [31:0] ram_read_data;
    logic        wb_valid;
    logic [31:0] result_out;
    logic        reg_write_en_out;
    logic [4:0]  reg_write_addr_out;
    logic [31:0] current_pc_addr_out;
    logic        misalign_flag;
    logic        bus_error_flag;

    modport slave (
        input  ex_valid, mem_read_flag_in, mem_write_flag_in, mem_sign_ext_flag_in,
               mem_sel_in, mem_write_data_in, result_in, reg_write_en_in,
               reg_write_addr_in, current_pc_addr_in, ram_ready, ram_read_data,
        output stall_req, mem_load_flag, ram_en, ram_write_en, ram_addr, ram_write_data,
               wb_valid, result_out, reg_write_en_out, reg_write_addr_out,
               current_pc_addr_out, misalign_flag, bus_error_flag
    );

    modport master (
        output ex_valid, mem_read_flag_in, mem_write_flag_in, mem_sign_ext_flag_in,
               mem_sel_in, mem_write_data_in, result_in, reg_write_en_in,
               reg_write_addr_in, current_pc_addr_in, ram_ready, ram_read_data,
        input  stall_req, mem_load_flag, ram_en, ram_write_en, ram_addr, ram_write_data,
               wb_valid, result_out, reg_write_en_out, reg_write_addr_out,
               current_pc_addr_out, misalign_flag, bus_error_flag
    );
endinterface

// File: rtl/mem_access.sv
// MEM stage: lane-aligns stores, extends loads, retires a registered bundle to WB.
// Latency: 1 cycle for non-memory/misaligned ops, 1 cycle after ram_ready for RAM ops.
// Backpressure: stall_req while a RAM access waits for ram_ready; BUS_TIMEOUT aborts it.
//
// Ports: clk, rst (synchronous, active high), bus (mem_access_if.slave: EX bundle in,
// RAM request/ready bus, WB bundle out). Only stall_req and mem_load_flag are combinational.
module mem_access #(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    mem_access_if.slave  bus
);
    // Counter only has to reach BUS_TIMEOUT-1 before the abort fires.
    localparam int CW = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT);

    typedef enum logic {IDLE, BUSY} state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        is_load;
        logic        is_store;
        logic        sext;
        logic [3:0]  sel;
        logic        reg_we;
        logic [4:0]  reg_addr;
        logic [31:0] pc;
    } acc_t;

    typedef struct packed {
        logic [31:0] result;
        logic        reg_we;
        logic [4:0]  reg_addr;
        logic [31:0] pc;
        logic        misalign;
        logic        bus_err;
    } wb_t;

    state_t      state_q, state_d;
    acc_t        acc_q;
    logic [CW-1:0] to_cnt_q;
    logic        wb_vld_q;
    wb_t         wb_q;
    logic        pend_vld_q;
    wb_t         pend_q;
    logic        ram_en_q;
    logic [3:0]  ram_we_q;
    logic [31:0] ram_addr_q;
    logic [31:0] ram_wdata_q;

    logic        stall;
    logic        accept;
    logic [1:0]  in_off;
    logic        in_mem;
    logic        in_mis;
    logic        start_mem;
    logic        new_ret;
    logic        old_ret;
    logic        timeout;
    logic        to_pend;
    wb_t         new_wb;
    wb_t         old_wb;
    logic [31:0] lane;
    logic [31:0] load_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        stall     = (state_q == BUSY) && !bus.ram_ready;
        accept    = bus.ex_valid && !stall;
        in_off    = bus.result_in[1:0];
        in_mem    = bus.mem_read_flag_in || bus.mem_write_flag_in;
        in_mis    = ((bus.mem_sel_in == 4'b0011) && in_off[0]) ||
                    ((bus.mem_sel_in == 4'b1111) && (in_off != 2'b00));
        start_mem = accept && in_mem && !in_mis;
        new_ret   = accept && (!in_mem || in_mis);
        timeout   = (state_q == BUSY) && !bus.ram_ready &&
                    (to_cnt_q == CW'(BUS_TIMEOUT - 1));
        old_ret   = (state_q == BUSY) && (bus.ram_ready || timeout);

        // Retirement produced directly by the op being accepted now.
        new_wb.result   = bus.result_in;
        new_wb.reg_we   = in_mem ? 1'b0 : bus.reg_write_en_in;
        new_wb.reg_addr = bus.reg_write_addr_in;
        new_wb.pc       = bus.current_pc_addr_in;
        new_wb.misalign = in_mem && in_mis;
        new_wb.bus_err  = 1'b0;

        // Load extraction from the addressed lane.
        lane = bus.ram_read_data >> {acc_q.addr[1:0], 3'b000};
        case (acc_q.sel)
            4'b0001: load_val = acc_q.sext ? {{24{lane[7]}}, lane[7:0]}   : {24'h0, lane[7:0]};
            4'b0011: load_val = acc_q.sext ? {{16{lane[15]}}, lane[15:0]} : {16'h0, lane[15:0]};
            default: load_val = lane;
        endcase

        // Retirement of the outstanding RAM access (completion or abort).
        old_wb.result   = (acc_q.is_load && !timeout) ? load_val : acc_q.addr;
        old_wb.reg_we   = acc_q.reg_we && !acc_q.is_store && !timeout;
        old_wb.reg_addr = acc_q.reg_addr;
        old_wb.pc       = acc_q.pc;
        old_wb.misalign = 1'b0;
        old_wb.bus_err  = timeout;

        // A non-memory or misaligned op accepted on the ram_ready cycle would retire on the
        // same edge as the finishing access; it is parked for one cycle in pend_q. The slot
        // drains every edge, so it never holds more than one bundle.
        to_pend = new_ret && (pend_vld_q || old_ret);

        state_d = state_q;
        case (state_q)
            IDLE: if (start_mem) state_d = BUSY;
            BUSY: if (old_ret)   state_d = start_mem ? BUSY : IDLE;
            default:             state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            to_cnt_q    <= '0;
            wb_vld_q    <= 1'b0;
            wb_q        <= '0;
            pend_vld_q  <= 1'b0;
            pend_q      <= '0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            if (state_q == BUSY && !bus.ram_ready && !timeout) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end else begin
                to_cnt_q <= '0;
            end

            // Oldest retirement first: parked bundle, then the RAM access, then the new op.
            if (pend_vld_q) begin
                wb_vld_q <= 1'b1;
                wb_q     <= pend_q;
            end else if (old_ret) begin
                wb_vld_q <= 1'b1;
                wb_q     <= old_wb;
            end else if (new_ret) begin
                wb_vld_q <= 1'b1;
                wb_q     <= new_wb;
            end else begin
                wb_vld_q <= 1'b0;
            end

            pend_vld_q <= to_pend;
            if (to_pend) begin
                pend_q <= new_wb;
            end

            if (start_mem) begin
                acc_q.addr     <= bus.result_in;
                acc_q.is_load  <= bus.mem_read_flag_in && !bus.mem_write_flag_in;
                acc_q.is_store <= bus.mem_write_flag_in;
                acc_q.sext     <= bus.mem_sign_ext_flag_in;
                acc_q.sel      <= bus.mem_sel_in;
                acc_q.reg_we   <= bus.reg_write_en_in;
                acc_q.reg_addr <= bus.reg_write_addr_in;
                acc_q.pc       <= bus.current_pc_addr_in;
                ram_en_q       <= 1'b1;
                ram_addr_q     <= {bus.result_in[31:2], 2'b00};
                ram_we_q       <= bus.mem_write_flag_in ? (bus.mem_sel_in << in_off) : 4'b0000;
                ram_wdata_q    <= bus.mem_write_data_in << {in_off, 3'b000};
            end else if (old_ret) begin
                ram_en_q <= 1'b0;
            end
        end
    end

    assign bus.stall_req           = stall;
    assign bus.mem_load_flag       = (state_q == BUSY) && acc_q.is_load;
    assign bus.ram_en              = ram_en_q;
    assign bus.ram_write_en        = ram_we_q;
    assign bus.ram_addr            = ram_addr_q;
    assign bus.ram_write_data      = ram_wdata_q;
    assign bus.wb_valid            = wb_vld_q;
    assign bus.result_out          = wb_q.result;
    assign bus.reg_write_en_out    = wb_q.reg_we;
    assign bus.reg_write_addr_out  = wb_q.reg_addr;
    assign bus.current_pc_addr_out = wb_q.pc;
    assign bus.misalign_flag       = wb_q.misalign;
    assign bus.bus_error_flag      = wb_q.bus_err;
endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios followed by random traffic.
// Latency: retirements are expected in order, one per edge, as early as possible.
// Backpressure: bench drives ram_ready itself and predicts stall_req from its own model.
module tb_mem_access;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_access_if bus();

    mem_access #(.BUS_TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit        rd, wr, sx;
        bit [3:0]  sel;
        bit [31:0] wd, res;
        bit        we;
        bit [4:0]  wa;
        bit [31:0] pc;
    } op_t;

    typedef struct {
        bit [31:0] res;
        bit        chk_res;
        bit        we;
        bit [4:0]  wa;
        bit [31:0] pc;
        bit        mis, berr;
    } ret_t;

    int   checks = 0;
    int   errors = 0;
    ret_t q[$];
    bit   m_busy = 0;
    int   m_cnt  = 0;
    int   m_wait = 0;
    op_t  m_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic op_t mk(bit rd, bit wr, bit sx, bit [3:0] sel, bit [31:0] wd,
                               bit [31:0] res, bit we, bit [4:0] wa, bit [31:0] pc);
        op_t o;
        o.rd = rd; o.wr = wr; o.sx = sx; o.sel = sel; o.wd = wd;
        o.res = res; o.we = we; o.wa = wa; o.pc = pc;
        return o;
    endfunction

    function automatic int nbytes(bit [3:0] sel);
        return (sel == 4'b0001) ? 1 : (sel == 4'b0011) ? 2 : 4;
    endfunction

    function automatic bit misal(op_t o);
        return (o.res % nbytes(o.sel)) != 0;
    endfunction

    // Gather the n addressed bytes, then extend by two's-complement arithmetic.
    function automatic bit [31:0] load_model(op_t o, bit [31:0] d);
        int        k = int'(o.res[1:0]);
        int        n = nbytes(o.sel);
        bit [31:0] v = 0;
        for (int i = 0; i < n; i++)
            v = v | (((d >> (8 * (k + i))) & 32'hFF) << (8 * i));
        if (o.sx && n < 4 && v[8 * n - 1])
            v = v - (32'd1 << (8 * n));
        return v;
    endfunction

    function automatic bit [3:0] we_model(op_t o);
        bit [3:0] w = 0;
        int k = int'(o.res[1:0]);
        if (o.wr)
            for (int i = 0; i < nbytes(o.sel); i++) w[k + i] = 1'b1;
        return w;
    endfunction

    // One clock cycle: drive inputs, check combinational/bus state, predict the edge, check WB.
    task automatic tick(input bit ev, input op_t o, input bit rdy, input bit [31:0] rdata,
                        input bit r);
        bit   stall_e;
        bit   have;
        ret_t e;
        ret_t n;
        bus.ex_valid             = ev;
        bus.mem_read_flag_in     = o.rd;
        bus.mem_write_flag_in    = o.wr;
        bus.mem_sign_ext_flag_in = o.sx;
        bus.mem_sel_in           = o.sel;
        bus.mem_write_data_in    = o.wd;
        bus.result_in            = o.res;
        bus.reg_write_en_in      = o.we;
        bus.reg_write_addr_in    = o.wa;
        bus.current_pc_addr_in   = o.pc;
        bus.ram_ready            = rdy;
        bus.ram_read_data        = rdata;
        rst                      = r;
        #1;
        stall_e = m_busy && !rdy;
        check("stall_req", bus.stall_req, stall_e);
        check("mem_load_flag", bus.mem_load_flag, m_busy && m_acc.rd && !m_acc.wr);
        check("ram_en", bus.ram_en, m_busy);
        if (m_busy) begin
            check("ram_addr", bus.ram_addr, m_acc.res & 32'hFFFF_FFFC);
            check("ram_write_en", bus.ram_write_en, we_model(m_acc));
            check("ram_write_data", bus.ram_write_data, m_acc.wd << (8 * m_acc.res[1:0]));
        end
        have = 0;
        if (r) begin
            m_busy = 0;
            m_cnt  = 0;
            q.delete();
        end else begin
            if (m_busy) begin
                n.wa = m_acc.wa; n.pc = m_acc.pc; n.mis = 0;
                if (rdy) begin
                    n.berr    = 0;
                    n.chk_res = !m_acc.wr;
                    n.res     = load_model(m_acc, rdata);
                    n.we      = m_acc.we && !m_acc.wr;
                    q.push_back(n);
                    m_busy = 0;
                end else begin
                    m_cnt++;
                    if (m_cnt == TO) begin
                        n.berr = 1; n.chk_res = 0; n.res = 0; n.we = 0;
                        q.push_back(n);
                        m_busy = 0;
                    end
                end
            end
            if (ev && !stall_e) begin
                n.res = o.res; n.chk_res = 1; n.wa = o.wa; n.pc = o.pc; n.berr = 0;
                if (!(o.rd || o.wr)) begin
                    n.we = o.we; n.mis = 0;
                    q.push_back(n);
                end else if (misal(o)) begin
                    n.we = 0; n.mis = 1;
                    q.push_back(n);
                end else begin
                    m_busy = 1;
                    m_cnt  = 0;
                    m_acc  = o;
                    m_wait = $urandom_range(0, 3);
                end
            end
            if (q.size() > 0) begin
                have = 1;
                e = q.pop_front();
            end
        end
        @(posedge clk);
        #1;
        check("wb_valid", bus.wb_valid, have);
        if (have && bus.wb_valid) begin
            if (e.chk_res) check("result_out", bus.result_out, e.res);
            check("reg_write_en_out", bus.reg_write_en_out, e.we);
            check("reg_write_addr_out", bus.reg_write_addr_out, e.wa);
            check("current_pc_addr_out", bus.current_pc_addr_out, e.pc);
            check("misalign_flag", bus.misalign_flag, e.mis);
            check("bus_error_flag", bus.bus_error_flag, e.berr);
        end
    endtask

    op_t nop;
    op_t o;
    op_t o2;

    initial begin
        nop = mk(0, 0, 0, 4'b0000, 0, 0, 0, 0, 0);
        bus.ex_valid = 0; bus.mem_read_flag_in = 0; bus.mem_write_flag_in = 0;
        bus.mem_sign_ext_flag_in = 0; bus.mem_sel_in = 0; bus.mem_write_data_in = 0;
        bus.result_in = 0; bus.reg_write_en_in = 0; bus.reg_write_addr_in = 0;
        bus.current_pc_addr_in = 0; bus.ram_ready = 0; bus.ram_read_data = 0;
        rst = 1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_wb_valid", bus.wb_valid, 0);
        check("rst_ram_en", bus.ram_en, 0);
        check("rst_ram_write_en", bus.ram_write_en, 0);
        check("rst_ram_addr", bus.ram_addr, 0);
        check("rst_ram_write_data", bus.ram_write_data, 0);
        check("rst_result_out", bus.result_out, 0);
        check("rst_reg_write_en_out", bus.reg_write_en_out, 0);
        check("rst_misalign", bus.misalign_flag, 0);
        check("rst_bus_error", bus.bus_error_flag, 0);
        check("rst_stall_req", bus.stall_req, 0);
        check("rst_mem_load_flag", bus.mem_load_flag, 0);

        // Non-memory op.
        tick(1, mk(0, 0, 0, 4'b0000, 0, 32'h1234, 1, 5, 32'h40), 0, 0, 0);
        check("alu_wb_valid", bus.wb_valid, 1);
        check("alu_result", bus.result_out, 32'h1234);
        check("alu_reg_we", bus.reg_write_en_out, 1);

        // Signed byte load at 0x103, three stalled cycles, then data.
        tick(1, mk(1, 0, 1, 4'b0001, 0, 32'h103, 1, 7, 32'h44), 0, 0, 0);
        check("lb_ram_addr", bus.ram_addr, 32'h100);
        check("lb_ram_write_en", bus.ram_write_en, 0);
        for (int i = 0; i < 3; i++) begin
            tick(0, nop, 0, 32'hDEAD_BEEF, 0);
            check("lb_stall_held", bus.stall_req, 1);
        end
        tick(0, nop, 1, 32'h80AA_BBCC, 0);
        check("lb_result", bus.result_out, 32'hFFFF_FF80);

        // Half store at 0x202.
        tick(1, mk(0, 1, 0, 4'b0011, 32'h0000_BEEF, 32'h202, 1, 9, 32'h48), 0, 0, 0);
        check("sh_write_en", bus.ram_write_en, 4'b1100);
        check("sh_write_data", bus.ram_write_data, 32'hBEEF_0000);
        tick(0, nop, 1, 0, 0);
        check("sh_reg_we", bus.reg_write_en_out, 0);

        // Misaligned word load.
        tick(1, mk(1, 0, 0, 4'b1111, 0, 32'h101, 1, 3, 32'h4C), 0, 0, 0);
        check("mis_ram_en", bus.ram_en, 0);
        check("mis_flag", bus.misalign_flag, 1);
        check("mis_reg_we", bus.reg_write_en_out, 0);

        // Timeout with ram_ready never asserted.
        tick(1, mk(1, 0, 0, 4'b1111, 0, 32'h300, 1, 4, 32'h50), 0, 0, 0);
        for (int i = 0; i < TO; i++) tick(0, nop, 0, 0, 0);
        check("to_bus_error", bus.bus_error_flag, 1);
        check("to_ram_en", bus.ram_en, 0);
        tick(0, nop, 0, 0, 0);

        // Back-to-back loads, then a non-memory op on the ready cycle.
        tick(1, mk(1, 0, 0, 4'b1111, 0, 32'h400, 1, 1, 32'h54), 0, 0, 0);
        tick(1, mk(1, 0, 1, 4'b0011, 0, 32'h406, 1, 2, 32'h58), 1, 32'h1111_2222, 0);
        check("b2b_ram_en", bus.ram_en, 1);
        check("b2b_ram_addr", bus.ram_addr, 32'h404);
        tick(1, mk(0, 0, 0, 4'b0000, 0, 32'h77, 1, 6, 32'h5C), 1, 32'h9876_5432, 0);
        tick(1, mk(0, 0, 0, 4'b0000, 0, 32'h78, 1, 8, 32'h60), 0, 0, 0);
        tick(0, nop, 0, 0, 0);
        tick(0, nop, 0, 0, 0);

        // Reset mid-access; the late ram_ready must not retire anything.
        tick(1, mk(1, 0, 0, 4'b1111, 0, 32'h500, 1, 10, 32'h64), 0, 0, 0);
        tick(0, nop, 0, 0, 0);
        tick(0, nop, 0, 0, 1);
        check("rst_mid_ram_en", bus.ram_en, 0);
        check("rst_mid_wb_valid", bus.wb_valid, 0);
        tick(0, nop, 1, 32'h1234_5678, 0);
        tick(0, nop, 0, 0, 0);

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            bit rdy;
            bit ev;
            int k;
            bit [3:0] sel;
            if (m_busy) begin
                rdy = (m_wait == 0);
                if (m_wait > 0) m_wait--;
            end else begin
                rdy = ($urandom_range(0, 3) == 0);
            end
            ev  = ($urandom_range(0, 9) < 7);
            k   = $urandom_range(0, 3);
            case ($urandom_range(0, 2))
                0:       sel = 4'b0001;
                1:       sel = 4'b0011;
                default: sel = 4'b1111;
            endcase
            o2 = mk(k == 1 || k == 3, k >= 2, 1'($urandom), sel, $urandom, $urandom,
                    1'($urandom), 5'($urandom), $urandom);
            tick(ev, o2, rdy, $urandom, 0);
        end
        for (int i = 0; i < 6; i++) tick(0, nop, 1, $urandom, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
